// File: rtl/frame_stream_source.sv
// frame_stream_source
//   Raster pixel source. On a start pulse it walks one frame of a synchronous
//   frame-buffer RAM in raster order and emits it as a pixel stream with
//   horizontal/vertical blanking and one-cycle sync pulses.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   start    one-cycle pulse, launches a frame when idle
//   rd_en    RAM read strobe
//   rd_addr  RAM address (v*WIDTH+h, kept incrementally)
//   rd_data  RAM read data, valid the cycle after rd_en
//   en       data carries an active pixel
//   hsync    one-cycle end-of-line pulse (cycle after the last pixel of a line)
//   vsync    one-cycle end-of-frame pulse
//   data     pixel {B,G,R}; zero whenever en=0
//   busy     frame in progress
//   done     one-cycle pulse once the frame has fully drained
//
// Timing: every stream event appears two cycles after the scan position that
// produced it (one cycle RAM latency, one output register stage).

module frame_stream_source #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 2,
  parameter int PIXEL_SIZE = 24,
  parameter int ADDR_W     = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  busy,
  output logic                  done
);

  localparam int H_TOT = WIDTH + H_BLANK;
  localparam int V_TOT = HEIGHT + V_BLANK;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Scan-position constants, sized to the counters. WIDTH < H_TOT and
  // HEIGHT < V_TOT, so all of them fit.
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(WIDTH);
  localparam logic [HW-1:0] H_ACT1 = HW'(WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(HEIGHT);
  localparam logic [VW-1:0] V_ACT1 = VW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          dcnt;

  // Stage between scan position and output register: read in flight,
  // pending hsync, pending vsync.
  logic          rd_vld;
  logic          hs_p;
  logic          vs_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      h       <= '0;
      v       <= '0;
      dcnt    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_vld  <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
      en      <= 1'b0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      data    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Output stage: capture RAM data the cycle after the read.
      rd_vld <= rd_en;
      en     <= rd_vld;
      data   <= rd_vld ? rd_data : '0;
      hsync  <= hs_p;
      vsync  <= vs_p;
      hs_p   <= 1'b0;
      vs_p   <= 1'b0;
      done   <= 1'b0;

      if (rd_en) rd_addr <= rd_addr + 1'b1;
      // busy stays high through the done cycle so a start there is ignored.
      if (done) busy <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !busy && !done) begin
            state   <= RUN;
            h       <= '0;
            v       <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;      // position (0,0) is always active
            rd_addr <= '0;
          end
        end

        RUN: begin
          hs_p <= (h == H_ACT) && (v < V_ACT);
          vs_p <= (h == '0) && (v == V_ACT);
          // rd_en is registered, so it is computed for the next position.
          if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
              v     <= '0;
              state <= DRAIN;
              dcnt  <= 1'b0;
              rd_en <= 1'b0;
            end else begin
              v     <= v + 1'b1;
              rd_en <= (v < V_ACT1);
            end
          end else begin
            h     <= h + 1'b1;
            rd_en <= (h < H_ACT1) && (v < V_ACT);
          end
        end

        DRAIN: begin
          // Two cycles to let the last sync/pixels leave the pipeline.
          if (dcnt) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            dcnt <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
